// File: rtl/adc_clk_sequencer.sv
// Startup and supervision controller for the ADC 160->320 MHz rate-changer clock.
// It resets the clock wizard, waits for a settled lock with bounded retries, and re-sequences on lock loss.
module adc_clk_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clkin160,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear_fault,
    input  logic       dcm_locked,
    output logic       dcm_reset,
    output logic       datapath_en,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int unsigned MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int          TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    lloss_q, lloss_d;
    logic          sync1_q, locked_s_q;
    logic          dcm_reset_q, ready_q, fault_q;
    logic          fail;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        lloss_d = lloss_q;
        fail    = 1'b0;
        if (state_q == ST_OFF) begin
            retry_d = '0;
        end
        // Dropping enable wins over everything except a latched fault.
        if (!enable && (state_q != ST_FAULT)) begin
            state_d = ST_OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_RST;
                    timer_d = '0;
                end
                ST_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        fail = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s_q) begin
                        fail = 1'b1;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_d = ST_RST;
                        timer_d = '0;
                        if (lloss_q != 8'hFF) begin
                            lloss_d = lloss_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        state_d = ST_OFF;
                        timer_d = '0;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end
            endcase
        end
        // A failed attempt retries from RST until the budget runs out.
        if (fail) begin
            timer_d = '0;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RST;
            end else begin
                state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clkin160 or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= ST_OFF;
            timer_q     <= '0;
            retry_q     <= '0;
            lloss_q     <= '0;
            dcm_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= dcm_locked;
            locked_s_q  <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            lloss_q     <= lloss_d;
            dcm_reset_q <= (state_d == ST_OFF) || (state_d == ST_RST) || (state_d == ST_FAULT);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign dcm_reset       = dcm_reset_q;
    assign datapath_en     = ready_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = lloss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_adc_clk_sequencer.sv
// Bench for adc_clk_sequencer: every state transition is matched against a queue of expected
// transitions carrying the outputs on entry and the cycles spent in the state just left.
module tb_adc_clk_sequencer;

    localparam int W = 35;
    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_WL     = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       clk = 1'b0;
    logic       reset, enable, clear_fault, dcm_locked;
    logic       dcm_reset, datapath_en, ready, fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_clk_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (32),
        .SETTLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clkin160       (clk),
        .reset          (reset),
        .enable         (enable),
        .clear_fault    (clear_fault),
        .dcm_locked     (dcm_locked),
        .dcm_reset      (dcm_reset),
        .datapath_en    (datapath_en),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    // Expected snapshot; a dwell of 0 means the time spent in the previous state is not checked.
    function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [3:0] rc,
                                          input logic [7:0] ll, input logic [15:0] dw);
        logic rst_e, run_e, flt_e;
        rst_e = (st == S_OFF) || (st == S_RST) || (st == S_FAULT);
        run_e = (st == S_RUN);
        flt_e = (st == S_FAULT);
        return {st, rst_e, run_e, run_e, flt_e, rc, ll, dw};
    endfunction

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("st=%0d dcm_reset=%0b dp_en=%0b ready=%0b fault=%0b retry=%0d lloss=%0d dwell=%0d",
                         v[34:32], v[31], v[30], v[29], v[28], v[27:24], v[23:16], v[15:0]);
    endfunction

    task automatic expect_tr(input logic [2:0] st, input logic [3:0] rc,
                             input logic [7:0] ll, input logic [15:0] dw);
        exp_q.push_back(pack(st, rc, ll, dw));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [2:0] st,
                             input logic [3:0] rc, input logic [7:0] ll);
        logic [W-1:0] act, exp;
        act = {state, dcm_reset, datapath_en, ready, fault, retry_count, lock_loss_count, 16'd0};
        exp = pack(st, rc, ll, 16'd0);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_drained(input string name);
        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: pending transitions=%0d, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_entry(input logic [2:0] tgt, input int budget);
        logic [2:0] p;
        bit hit;
        p = state;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #1;
            if (state == tgt && p != tgt) hit = 1'b1;
            p = state;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_entry: state %0d not entered within %0d cycles, state=%0d", tgt, budget, state);
        end
    endtask

    // Transition monitor: pops one expected entry per observed state change.
    initial begin : monitor
        int cyc, last, d;
        logic [2:0] prev;
        logic [W-1:0] act, exp;
        cyc = 0;
        last = 0;
        prev = S_OFF;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev = state;
                last = cyc;
            end else if (state !== prev) begin
                d = cyc - last;
                last = cyc;
                prev = state;
                act = {state, dcm_reset, datapath_en, ready, fault, retry_count, lock_loss_count, 16'(d)};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transition: got %s, required no change", fmt(act));
                end else begin
                    exp = exp_q.pop_front();
                    if (exp[15:0] == 16'd0) act[15:0] = 16'd0;
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL transition: got %s, required %s", fmt(act), fmt(exp));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ll_e;
        reset = 1'b1;
        enable = 1'b0;
        clear_fault = 1'b0;
        dcm_locked = 1'b0;
        tick(3);
        check_now("reset_values", S_OFF, 4'd0, 8'd0);
        reset = 1'b0;
        tick(3);
        check_now("idle_off", S_OFF, 4'd0, 8'd0);

        // Nominal bring-up, lock arriving 10 cycles into WAIT_LOCK.
        expect_tr(S_RST, 4'd0, 8'd0, 16'd0);
        expect_tr(S_WL, 4'd0, 8'd0, 16'd4);
        expect_tr(S_SETTLE, 4'd0, 8'd0, 16'd13);
        expect_tr(S_RUN, 4'd0, 8'd0, 16'd8);
        enable = 1'b1;
        wait_entry(S_WL, 20);
        tick(10);
        dcm_locked = 1'b1;
        wait_entry(S_RUN, 30);
        check_now("t1_run", S_RUN, 4'd0, 8'd0);
        check_drained("t1_drain");

        // enable and synchronized lock drop seen on the same edge.
        expect_tr(S_OFF, 4'd0, 8'd0, 16'd0);
        dcm_locked = 1'b0;
        tick(2);
        enable = 1'b0;
        tick(3);
        check_now("t6_priority_off", S_OFF, 4'd0, 8'd0);
        check_drained("t6_priority_drain");

        // Two timeouts, then lock during the third attempt.
        expect_tr(S_RST, 4'd0, 8'd0, 16'd0);
        expect_tr(S_WL, 4'd0, 8'd0, 16'd4);
        expect_tr(S_RST, 4'd1, 8'd0, 16'd32);
        expect_tr(S_WL, 4'd1, 8'd0, 16'd4);
        expect_tr(S_RST, 4'd2, 8'd0, 16'd32);
        expect_tr(S_WL, 4'd2, 8'd0, 16'd4);
        expect_tr(S_SETTLE, 4'd2, 8'd0, 16'd5);
        expect_tr(S_RUN, 4'd0, 8'd0, 16'd8);
        enable = 1'b1;
        wait_entry(S_WL, 20);
        wait_entry(S_WL, 60);
        wait_entry(S_WL, 60);
        tick(2);
        dcm_locked = 1'b1;
        wait_entry(S_RUN, 30);
        check_now("t2_run", S_RUN, 4'd0, 8'd0);
        check_drained("t2_drain");

        // Lock glitch at settle cycle 5.
        expect_tr(S_OFF, 4'd0, 8'd0, 16'd0);
        enable = 1'b0;
        tick(2);
        expect_tr(S_RST, 4'd0, 8'd0, 16'd0);
        expect_tr(S_WL, 4'd0, 8'd0, 16'd4);
        expect_tr(S_SETTLE, 4'd0, 8'd0, 16'd1);
        expect_tr(S_RST, 4'd1, 8'd0, 16'd5);
        expect_tr(S_WL, 4'd1, 8'd0, 16'd4);
        expect_tr(S_SETTLE, 4'd1, 8'd0, 16'd1);
        expect_tr(S_RUN, 4'd0, 8'd0, 16'd8);
        enable = 1'b1;
        wait_entry(S_SETTLE, 20);
        tick(2);
        dcm_locked = 1'b0;
        tick(1);
        dcm_locked = 1'b1;
        wait_entry(S_RUN, 40);
        check_now("t5_run", S_RUN, 4'd0, 8'd0);
        check_drained("t5_drain");

        // Runtime lock loss, repeated past the counter's saturation point.
        for (int i = 1; i <= 260; i++) begin
            ll_e = (i > 255) ? 8'd255 : 8'(i);
            expect_tr(S_RST, 4'd0, ll_e, 16'd0);
            expect_tr(S_WL, 4'd0, ll_e, 16'd4);
            expect_tr(S_SETTLE, 4'd0, ll_e, 16'd1);
            expect_tr(S_RUN, 4'd0, ll_e, 16'd8);
            dcm_locked = 1'b0;
            tick(1);
            dcm_locked = 1'b1;
            if (i == 1) begin
                tick(1);
                check_now("t4_edge2_still_run", S_RUN, 4'd0, 8'd0);
                tick(1);
                check_now("t4_edge3_dp_off", S_RST, 4'd0, 8'd1);
            end
            wait_entry(S_RUN, 40);
        end
        check_now("t4_saturated", S_RUN, 4'd0, 8'd255);
        check_drained("t4_drain");

        // Retries exhausted, fault latched, then cleared.
        expect_tr(S_OFF, 4'd0, 8'd255, 16'd0);
        enable = 1'b0;
        dcm_locked = 1'b0;
        tick(3);
        expect_tr(S_RST, 4'd0, 8'd255, 16'd0);
        expect_tr(S_WL, 4'd0, 8'd255, 16'd4);
        expect_tr(S_RST, 4'd1, 8'd255, 16'd32);
        expect_tr(S_WL, 4'd1, 8'd255, 16'd4);
        expect_tr(S_RST, 4'd2, 8'd255, 16'd32);
        expect_tr(S_WL, 4'd2, 8'd255, 16'd4);
        expect_tr(S_FAULT, 4'd2, 8'd255, 16'd32);
        enable = 1'b1;
        wait_entry(S_FAULT, 200);
        check_now("t3_fault", S_FAULT, 4'd2, 8'd255);
        enable = 1'b0;
        tick(3);
        check_now("t3_fault_enable_low", S_FAULT, 4'd2, 8'd255);
        enable = 1'b1;
        tick(3);
        check_now("t3_fault_enable_high", S_FAULT, 4'd2, 8'd255);
        expect_tr(S_OFF, 4'd0, 8'd255, 16'd0);
        expect_tr(S_RST, 4'd0, 8'd255, 16'd1);
        expect_tr(S_WL, 4'd0, 8'd255, 16'd4);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check_now("t3_cleared", S_OFF, 4'd0, 8'd255);
        wait_entry(S_WL, 20);
        check_drained("t3_drain");

        // Asynchronous reset in the middle of WAIT_LOCK.
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check_now("t6_async_reset", S_OFF, 4'd0, 8'd0);
        enable = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        check_now("t6_after_release", S_OFF, 4'd0, 8'd0);
        check_drained("t6_reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
